axi4_lite_master_bridge: RTL and testbench

//  Initiator-side AXI4-Lite bridge: turns single-beat requests from a local register/DMA client into AXI4-Lite

---
 rtl/axi4_lite_master_bridge.sv | 228 ++++++++++++++++++++++
 tb/tb_axi4_lite_master_bridge.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_master_bridge.sv
// AXI4-Lite master bridge: turns single-beat client requests into AXI4-Lite
// read/write transactions, one at a time, and returns the completion to the client.
// All AXI-facing outputs and the client response come straight from registers.
module axi4_lite_master_bridge #(
    parameter int AXI_ID_WIDTH   = 1,
    parameter int AXI_ADDR_WIDTH = 12,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int ID_VALUE       = 0
) (
    input  logic                        aclk,
    input  logic                        reset,
    // client request
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [AXI_ADDR_WIDTH-1:0]   req_addr,
    input  logic [AXI_DATA_WIDTH-1:0]   req_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] req_wstrb,
    input  logic [2:0]                  req_prot,
    // client response
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                  rsp_resp,
    // write address channel
    output logic [AXI_ID_WIDTH-1:0]     awid,
    output logic [AXI_ADDR_WIDTH-1:0]   awaddr,
    output logic [2:0]                  awprot,
    output logic                        awvalid,
    input  logic                        awready,
    // write data channel
    output logic [AXI_DATA_WIDTH-1:0]   wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] wstrb,
    output logic                        wvalid,
    input  logic                        wready,
    // write response channel
    input  logic [AXI_ID_WIDTH-1:0]     bid,
    input  logic [1:0]                  bresp,
    input  logic                        bvalid,
    output logic                        bready,
    // read address channel
    output logic [AXI_ID_WIDTH-1:0]     arid,
    output logic [AXI_ADDR_WIDTH-1:0]   araddr,
    output logic [2:0]                  arprot,
    output logic                        arvalid,
    input  logic                        arready,
    // read data channel
    input  logic [AXI_ID_WIDTH-1:0]     rid,
    input  logic [AXI_DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]                  rresp,
    input  logic                        rvalid,
    output logic                        rready
);

    localparam int BYTE_COUNT = AXI_DATA_WIDTH / 8;
    localparam logic [AXI_ID_WIDTH-1:0] ID_CONST = AXI_ID_WIDTH'(ID_VALUE);
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RSP
    } state_t;

    state_t                      state_reg, state_next;
    logic [AXI_ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [AXI_DATA_WIDTH-1:0]   wdata_reg, wdata_next;
    logic [BYTE_COUNT-1:0]       wstrb_reg, wstrb_next;
    logic [2:0]                  prot_reg, prot_next;
    logic                        awvalid_reg, awvalid_next;
    logic                        wvalid_reg, wvalid_next;
    logic                        bready_reg, bready_next;
    logic                        arvalid_reg, arvalid_next;
    logic                        rready_reg, rready_next;
    logic                        rsp_valid_reg, rsp_valid_next;
    logic [AXI_DATA_WIDTH-1:0]   rsp_rdata_reg, rsp_rdata_next;
    logic [1:0]                  rsp_resp_reg, rsp_resp_next;

    // A channel is finished once its valid has been accepted (or was already dropped).
    logic aw_done;
    logic w_done;
    assign aw_done = !awvalid_reg || awready;
    assign w_done  = !wvalid_reg  || wready;

    // State and all registered outputs; reset abandons any transaction in flight.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            prot_reg      <= '0;
            awvalid_reg   <= 1'b0;
            wvalid_reg    <= 1'b0;
            bready_reg    <= 1'b0;
            arvalid_reg   <= 1'b0;
            rready_reg    <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_resp_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            wstrb_reg     <= wstrb_next;
            prot_reg      <= prot_next;
            awvalid_reg   <= awvalid_next;
            wvalid_reg    <= wvalid_next;
            bready_reg    <= bready_next;
            arvalid_reg   <= arvalid_next;
            rready_reg    <= rready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_resp_reg  <= rsp_resp_next;
        end
    end

    // Next-state logic and next values of the registered channel signals.
    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        wstrb_next     = wstrb_reg;
        prot_next      = prot_reg;
        awvalid_next   = awvalid_reg;
        wvalid_next    = wvalid_reg;
        bready_next    = bready_reg;
        arvalid_next   = arvalid_reg;
        rready_next    = rready_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_resp_next  = rsp_resp_reg;

        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    addr_next  = req_addr;
                    wdata_next = req_wdata;
                    wstrb_next = req_wstrb;
                    prot_next  = req_prot;
                    if (req_write) begin
                        awvalid_next = 1'b1;
                        wvalid_next  = 1'b1;
                        state_next   = WR_REQ;
                    end else begin
                        arvalid_next = 1'b1;
                        state_next   = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                // AW and W complete independently, in any order.
                if (awvalid_reg && awready) begin
                    awvalid_next = 1'b0;
                end
                if (wvalid_reg && wready) begin
                    wvalid_next = 1'b0;
                end
                if (aw_done && w_done) begin
                    bready_next = 1'b1;
                    state_next  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bvalid && bready_reg) begin
                    bready_next    = 1'b0;
                    rsp_rdata_next = '0;
                    rsp_resp_next  = (bid != ID_CONST) ? RESP_SLVERR : bresp;
                    rsp_valid_next = 1'b1;
                    state_next     = RSP;
                end
            end
            RD_REQ: begin
                if (arready) begin
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                    state_next   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rvalid && rready_reg) begin
                    rready_next    = 1'b0;
                    rsp_rdata_next = rdata;
                    rsp_resp_next  = (rid != ID_CONST) ? RESP_SLVERR : rresp;
                    rsp_valid_next = 1'b1;
                    state_next     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign req_ready = (state_reg == IDLE);

    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_resp  = rsp_resp_reg;

    assign awid    = ID_CONST;
    assign awaddr  = addr_reg;
    assign awprot  = prot_reg;
    assign awvalid = awvalid_reg;

    assign wdata  = wdata_reg;
    assign wstrb  = wstrb_reg;
    assign wvalid = wvalid_reg;

    assign bready = bready_reg;

    assign arid    = ID_CONST;
    assign araddr  = addr_reg;
    assign arprot  = prot_reg;
    assign arvalid = arvalid_reg;

    assign rready = rready_reg;

endmodule

// File: tb/tb_axi4_lite_master_bridge.sv
// Bench for axi4_lite_master_bridge: a configurable AXI4-Lite slave, a
// transaction-level model of the client side, and one per-cycle compare process.
module tb_axi4_lite_master_bridge;

    localparam int IDW = 1;
    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int BW  = DW / 8;
    localparam logic [IDW-1:0] IDV = '0;

    logic aclk = 1'b0;
    logic reset;
    always #5 aclk = ~aclk;

    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [BW-1:0] req_wstrb;
    logic [2:0]    req_prot;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [IDW-1:0] awid, bid, arid, rid;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [BW-1:0] wstrb;
    logic [1:0]    bresp, rresp;

    axi4_lite_master_bridge #(
        .AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .ID_VALUE(0)
    ) dut (
        .aclk(aclk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .awid(awid), .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- slave configuration (set by the stimulus) ----------------
    int             cfg_aw_delay = 0;
    int             cfg_w_delay = 0;
    int             cfg_ar_delay = 0;
    int             cfg_rsp_hold = 0;
    logic [1:0]     cfg_resp = 2'b00;
    logic [IDW-1:0] cfg_id = '0;
    logic [DW-1:0]  cfg_rdata = '0;

    // ---------------- slave state ----------------
    int aw_cnt, w_cnt, ar_cnt, rsp_cnt;
    logic aw_got, w_got, ar_got;
    logic [7:0] aw_n, w_n, ar_n;
    logic [AW-1:0] last_awaddr, last_araddr;
    logic [IDW-1:0] last_awid;
    logic [DW-1:0] last_wdata;
    logic [BW-1:0] last_wstrb;
    logic [DW-1:0] exp_rdata;
    logic [1:0] exp_resp;

    // Each ready rises after the valid has waited the configured number of cycles.
    assign awready   = (aw_cnt >= cfg_aw_delay);
    assign wready    = (w_cnt >= cfg_w_delay);
    assign arready   = (ar_cnt >= cfg_ar_delay);
    assign rsp_ready = (rsp_cnt >= cfg_rsp_hold);

    // Slave: answers one cycle after the request handshakes; records what it saw.
    always @(posedge aclk or posedge reset) begin
        if (reset) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; rsp_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
            bvalid <= 1'b0; bresp <= '0; bid <= '0;
            rvalid <= 1'b0; rresp <= '0; rid <= '0; rdata <= '0;
            aw_n <= '0; w_n <= '0; ar_n <= '0;
            last_awaddr <= '0; last_araddr <= '0; last_awid <= '0;
            last_wdata <= '0; last_wstrb <= '0;
            exp_rdata <= '0; exp_resp <= '0;
        end else begin
            if (req_valid && req_ready) begin
                aw_n <= '0; w_n <= '0; ar_n <= '0;
            end
            if (awvalid && awready) begin
                aw_cnt <= 0; aw_got <= 1'b1; aw_n <= aw_n + 8'd1;
                last_awaddr <= awaddr; last_awid <= awid;
            end else if (awvalid) aw_cnt <= aw_cnt + 1;
            else aw_cnt <= 0;
            if (wvalid && wready) begin
                w_cnt <= 0; w_got <= 1'b1; w_n <= w_n + 8'd1;
                last_wdata <= wdata; last_wstrb <= wstrb;
            end else if (wvalid) w_cnt <= w_cnt + 1;
            else w_cnt <= 0;
            if (arvalid && arready) begin
                ar_cnt <= 0; ar_got <= 1'b1; ar_n <= ar_n + 8'd1;
                last_araddr <= araddr;
            end else if (arvalid) ar_cnt <= ar_cnt + 1;
            else ar_cnt <= 0;
            if (rsp_valid && !rsp_ready) rsp_cnt <= rsp_cnt + 1;
            else rsp_cnt <= 0;
            if (aw_got && w_got && !bvalid) begin
                bvalid <= 1'b1; bresp <= cfg_resp; bid <= cfg_id;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
                exp_rdata <= '0;
                exp_resp <= (bid != IDV) ? 2'b10 : bresp;
            end
            if (ar_got && !rvalid) begin
                rvalid <= 1'b1; rdata <= cfg_rdata; rresp <= cfg_resp; rid <= cfg_id;
            end
            if (rvalid && rready) begin
                rvalid <= 1'b0; ar_got <= 1'b0;
                exp_rdata <= rdata;
                exp_resp <= (rid != IDV) ? 2'b10 : rresp;
            end
        end
    end

    // ---------------- client-side transaction model ----------------
    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    logic busy;
    logic acc_write;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;
    logic [BW-1:0] acc_wstrb;
    logic [2:0] acc_prot;
    int acc_cyc;
    int n_rsp;
    logic [DW-1:0] last_rsp_rdata;
    logic [1:0] last_rsp_resp;

    // One request outstanding from accept until its response is consumed.
    always @(posedge aclk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0; acc_write <= 1'b0; acc_addr <= '0; acc_wdata <= '0;
            acc_wstrb <= '0; acc_prot <= '0; acc_cyc <= 0;
        end else begin
            if (req_valid && req_ready) begin
                busy <= 1'b1; acc_write <= req_write; acc_addr <= req_addr;
                acc_wdata <= req_wdata; acc_wstrb <= req_wstrb; acc_prot <= req_prot;
                acc_cyc <= cyc;
            end
            if (rsp_valid && rsp_ready) begin
                busy <= 1'b0;
                n_rsp <= n_rsp + 1;
                last_rsp_rdata <= rsp_rdata;
                last_rsp_resp <= rsp_resp;
            end
        end
    end
    initial n_rsp = 0;

    // ---------------- per-cycle compare ----------------
    logic p_awvalid, p_awready, p_wvalid, p_wready, p_arvalid, p_arready;
    logic p_rsp_valid, p_rsp_ready;
    logic [AW-1:0] p_awaddr, p_araddr;
    logic [DW-1:0] p_wdata, p_rsp_rdata;
    logic [1:0] p_rsp_resp;
    int last_lat = 0;
    int rsp_hi = 0;
    int last_rsp_cycles = 0;

    // Checks the DUT outputs against the model on every falling edge.
    always @(negedge aclk) begin
        if (reset) begin
            chk("reset_req_ready", 64'(req_ready), 64'd1);
            chk("reset_valids", 64'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 64'd0);
            chk("reset_rsp", 64'({rsp_rdata, rsp_resp}), 64'd0);
            chk("reset_regs", 64'({awaddr, awprot, wstrb, wdata}), 64'd0);
            p_awvalid = 0; p_awready = 0; p_wvalid = 0; p_wready = 0;
            p_arvalid = 0; p_arready = 0; p_rsp_valid = 0; p_rsp_ready = 0;
            rsp_hi = 0;
        end else begin
            chk("req_ready", 64'(req_ready), 64'(!busy));
            if (!busy)
                chk("idle_quiet", 64'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 64'd0);
            chk("req_resp_overlap", 64'((awvalid | wvalid | arvalid) & (bready | rready)), 64'd0);
            if (awvalid)
                chk("aw_payload", 64'({acc_write, awaddr, awprot, awid}), 64'({1'b1, acc_addr, acc_prot, IDV}));
            if (wvalid)
                chk("w_payload", 64'({acc_write, wdata, wstrb}), 64'({1'b1, acc_wdata, acc_wstrb}));
            if (arvalid)
                chk("ar_payload", 64'({acc_write, araddr, arprot, arid}), 64'({1'b0, acc_addr, acc_prot, IDV}));
            if (bready)
                chk("bready_after_aw_w", 64'({acc_write, aw_got, w_got}), 64'd7);
            if (rready)
                chk("rready_after_ar", 64'({acc_write, ar_got}), 64'd1);
            if (p_awvalid && !p_awready)
                chk("aw_hold", 64'({awvalid, awaddr}), 64'({1'b1, p_awaddr}));
            if (p_wvalid && !p_wready)
                chk("w_hold", 64'({wvalid, wdata}), 64'({1'b1, p_wdata}));
            if (p_arvalid && !p_arready)
                chk("ar_hold", 64'({arvalid, araddr}), 64'({1'b1, p_araddr}));
            if (p_rsp_valid && !p_rsp_ready)
                chk("rsp_hold", 64'({rsp_valid, rsp_rdata, rsp_resp}), 64'({1'b1, p_rsp_rdata, p_rsp_resp}));
            if (rsp_valid) begin
                chk("rsp_value", 64'({rsp_rdata, rsp_resp}), 64'({exp_rdata, exp_resp}));
                if (!p_rsp_valid) begin
                    last_lat = cyc - acc_cyc;
                    chk("handshake_counts", 64'({aw_n, w_n, ar_n}),
                        acc_write ? 64'h010100 : 64'h000001);
                end
                rsp_hi++;
                if (rsp_ready) begin
                    last_rsp_cycles = rsp_hi;
                    rsp_hi = 0;
                end
            end
            p_awvalid = awvalid; p_awready = awready; p_awaddr = awaddr;
            p_wvalid = wvalid; p_wready = wready; p_wdata = wdata;
            p_arvalid = arvalid; p_arready = arready; p_araddr = araddr;
            p_rsp_valid = rsp_valid; p_rsp_ready = rsp_ready;
            p_rsp_rdata = rsp_rdata; p_rsp_resp = rsp_resp;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge aclk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [BW-1:0] s, input logic [2:0] p, input bit keep);
        int n = 0;
        req_write = w; req_addr = a; req_wdata = d; req_wstrb = s; req_prot = p;
        req_valid = 1'b1;
        while (!req_ready && n < 200) begin
            step();
            n++;
        end
        chk("accept_wait", 64'(req_ready), 64'd1);
        step();
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            step();
            n++;
        end
        chk("idle_wait", 64'(busy), 64'd0);
    endtask

    int aw_d[3] = '{3, 0, 2};
    int w_d[3]  = '{0, 3, 2};
    int lat_e[3] = '{7, 7, 6};
    int n0;

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_wstrb = '0; req_prot = '0;
        repeat (3) step();
        reset = 1'b0;
        step();

        // Write, slave always ready, OKAY
        issue(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 3'b000, 1'b0);
        wait_idle();
        chk("t1_awaddr", 64'(last_awaddr), 64'h010);
        chk("t1_wdata", 64'(last_wdata), 64'hDEADBEEF);
        chk("t1_wstrb", 64'(last_wstrb), 64'hF);
        chk("t1_awid", 64'(last_awid), 64'd0);
        chk("t1_rsp", 64'({last_rsp_rdata, last_rsp_resp}), 64'd0);
        chk("t1_latency", 64'(last_lat), 64'd4);

        // W before AW, AW before W, both together
        for (int k = 0; k < 3; k++) begin
            cfg_aw_delay = aw_d[k];
            cfg_w_delay = w_d[k];
            issue(1'b1, 12'h100 + 12'(4 * k), 32'h1000 + 32'(k), 4'h5, 3'b010, 1'b0);
            wait_idle();
            chk("t2_counts", 64'({aw_n, w_n}), 64'h0101);
            chk("t2_latency", 64'(last_lat), 64'(lat_e[k]));
            chk("t2_rsp", 64'({last_rsp_rdata, last_rsp_resp}), 64'd0);
        end
        cfg_aw_delay = 0;
        cfg_w_delay = 0;

        // Read with SLVERR
        cfg_rdata = 32'h12345678;
        cfg_resp = 2'b10;
        issue(1'b0, 12'h020, 32'h0, 4'h0, 3'b001, 1'b0);
        wait_idle();
        chk("t3_araddr", 64'(last_araddr), 64'h020);
        chk("t3_rdata", 64'(last_rsp_rdata), 64'h12345678);
        chk("t3_resp", 64'(last_rsp_resp), 64'h2);
        chk("t3_latency", 64'(last_lat), 64'd4);

        // bid mismatch with OKAY, client slow to take the response
        cfg_resp = 2'b00;
        cfg_id = 1'b1;
        cfg_rsp_hold = 5;
        issue(1'b1, 12'h044, 32'h55AA55AA, 4'hC, 3'b000, 1'b0);
        wait_idle();
        chk("t4_bid_resp", 64'({last_rsp_rdata, last_rsp_resp}), 64'h2);
        chk("t4_rsp_cycles", 64'(last_rsp_cycles), 64'd6);
        cfg_rsp_hold = 0;

        // rid mismatch with OKAY
        cfg_rdata = 32'h0000A5A5;
        issue(1'b0, 12'h048, 32'h0, 4'h0, 3'b000, 1'b0);
        wait_idle();
        chk("t4_rid_rdata", 64'(last_rsp_rdata), 64'h0000A5A5);
        chk("t4_rid_resp", 64'(last_rsp_resp), 64'h2);
        cfg_id = 1'b0;

        // Back-to-back read/write/read with req_valid held high
        cfg_rdata = 32'h0BADF00D;
        n0 = n_rsp;
        issue(1'b0, 12'h030, 32'h0, 4'h0, 3'b000, 1'b1);
        issue(1'b1, 12'h034, 32'hCAFEF00D, 4'h3, 3'b101, 1'b1);
        issue(1'b0, 12'h038, 32'h0, 4'h0, 3'b000, 1'b0);
        wait_idle();
        chk("t5_rsp_count", 64'(n_rsp - n0), 64'd3);
        chk("t5_awaddr", 64'(last_awaddr), 64'h034);
        chk("t5_wdata", 64'(last_wdata), 64'hCAFEF00D);
        chk("t5_araddr", 64'(last_araddr), 64'h038);
        chk("t5_last_rdata", 64'(last_rsp_rdata), 64'h0BADF00D);

        // Reset while awvalid is waiting for awready
        cfg_aw_delay = 20;
        issue(1'b1, 12'h0F0, 32'h77777777, 4'hF, 3'b000, 1'b0);
        chk("t6_awvalid_before", 64'(awvalid), 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("t6_valids_in_reset", 64'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 64'd0);
        step();
        reset = 1'b0;
        cfg_aw_delay = 0;
        step();
        chk("t6_ready_after", 64'(req_ready), 64'd1);

        // Normal operation after the abandoned transaction
        cfg_rdata = 32'h5A5A5A5A;
        issue(1'b0, 12'h0FC, 32'h0, 4'h0, 3'b000, 1'b0);
        wait_idle();
        chk("t7_rdata", 64'({last_rsp_rdata, last_rsp_resp}), 64'({32'h5A5A5A5A, 2'b00}));
        chk("t7_latency", 64'(last_lat), 64'd4);

        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
